// File: rtl/alu_pkg.sv
// Shared constants for the shift/add multiply-divide datapath.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the default operand width and the bit index of every action in the
// 11-bit control word c[10:0].
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int C_BITS    = 11;

  localparam int C_LOAD_M  = 0;   // M <= sext(inbus), clear A, q_1, cnt
  localparam int C_LOAD_Q  = 1;   // Q <= inbus
  localparam int C_ADD     = 2;   // A <= A + M
  localparam int C_SUB     = 3;   // A <= A - M (wins over C_ADD)
  localparam int C_ASR     = 4;   // arithmetic shift right {A,Q,q_1}
  localparam int C_CNT     = 5;   // cnt <= cnt + 1
  localparam int C_OUT_A   = 6;   // outbus <= A[WIDTH-1:0]
  localparam int C_OUT_Q   = 7;   // outbus <= Q
  localparam int C_SHL     = 8;   // shift left {A,Q}, Q[0] <= 0
  localparam int C_QBIT    = 9;   // Q[0] <= ~sign of post-add/sub A
  localparam int C_CORR    = 10;  // A <= A + M when A is negative

endpackage

// File: rtl/alu_adder.sv
// Two's complement add/subtract of N-bit operands, carry-out discarded.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   a, b  operands (N bits)
//   sub   1 = a - b, 0 = a + b (also used as carry-in)
//   sum   N-bit result
module alu_adder #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  logic [N-1:0] b_eff;
  logic [N-1:0] cin;

  // Subtract as a + ~b + 1; the +1 rides in on the carry.
  assign b_eff = b ^ {N{sub}};
  assign cin   = {{(N-1){1'b0}}, sub};
  assign sum   = a + b_eff + cin;

endmodule

// File: rtl/alu_datapath.sv
// Booth multiply / restoring divide datapath driven by a one-hot control word.
// Latency: every action completes at the next rising edge; outbus one cycle.
// Backpressure: none; the control unit sequences every cycle explicitly.
//
// Optional feature: define ALU_DATAPATH_OVF_EN to add a sticky ovf output.
//
// Ports:
//   clk, rst_b      clock, synchronous active-low reset
//   c[10:0]         control word (indices in alu_pkg)
//   inbus           operand input bus
//   q0, q_1, a_8    Q[0], Booth history bit, accumulator sign bit
//   cnt             iteration counter
//   outbus          registered result word, out_valid pulses when updated
//   ovf             (optional) sticky signed-overflow flag
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [C_BITS-1:0]        c,
  input  logic [WIDTH-1:0]         inbus,
  output logic                     q0,
  output logic                     q_1,
  output logic                     a_8,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic [WIDTH-1:0]         outbus,
`ifdef ALU_DATAPATH_OVF_EN
  output logic                     ovf,
`endif
  output logic                     out_valid
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   m;
  logic             q1;
  logic [CW-1:0]    cnt_r;

  logic             arith_en;
  logic             arith_sub;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_arith;
  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             q1_nxt;

  // Subtract wins when both add and subtract are requested. The restoring
  // correction is an add, and only acts when no explicit add/sub is present.
  assign arith_sub = c[C_SUB];
  assign arith_en  = c[C_ADD] | c[C_SUB] | (c[C_CORR] & a[WIDTH]);

  alu_adder #(.N(WIDTH + 1)) u_adder (
    .a   (a),
    .b   (m),
    .sub (arith_sub),
    .sum (sum)
  );

  // Ordering inside one cycle: add/sub, then shift on the sum, then the
  // quotient bit. Conflicting shift requests cancel each other.
  always_comb begin
    a_arith = arith_en ? sum : a;
    a_nxt   = a_arith;
    q_nxt   = q;
    q1_nxt  = q1;
    if (c[C_ASR] && !c[C_SHL]) begin
      a_nxt  = {a_arith[WIDTH], a_arith[WIDTH:1]};
      q_nxt  = {a_arith[0], q[WIDTH-1:1]};
      q1_nxt = q[0];
    end else if (c[C_SHL] && !c[C_ASR]) begin
      a_nxt  = {a_arith[WIDTH-1:0], q[WIDTH-1]};
      q_nxt  = {q[WIDTH-2:0], 1'b0};
    end
    if (c[C_QBIT]) begin
      q_nxt[0] = ~a_arith[WIDTH];
    end
  end

`ifdef ALU_DATAPATH_OVF_EN
  logic ovf_r;
  logic ovf_now;
  // Flag both a true WIDTH+1-bit wrap and a result that no longer fits the
  // WIDTH-bit word visible on outbus (sign bit disagrees with A[WIDTH-1]).
  assign ovf_now = arith_en &
                   (((a[WIDTH] ~^ (m[WIDTH] ^ arith_sub)) & (sum[WIDTH] ^ a[WIDTH])) |
                    (sum[WIDTH] ^ sum[WIDTH-1]));
`endif

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      a         <= '0;
      q         <= '0;
      m         <= '0;
      q1        <= 1'b0;
      cnt_r     <= '0;
      outbus    <= '0;
      out_valid <= 1'b0;
`ifdef ALU_DATAPATH_OVF_EN
      ovf_r     <= 1'b0;
`endif
    end else begin
      if (c[C_LOAD_M]) begin
        m     <= {inbus[WIDTH-1], inbus};
        a     <= '0;
        q1    <= 1'b0;
        cnt_r <= '0;
`ifdef ALU_DATAPATH_OVF_EN
        ovf_r <= 1'b0;
`endif
      end else begin
        a  <= a_nxt;
        q1 <= q1_nxt;
        if (c[C_CNT]) begin
          cnt_r <= cnt_r + 1'b1;
        end
`ifdef ALU_DATAPATH_OVF_EN
        if (ovf_now) begin
          ovf_r <= 1'b1;
        end
`endif
      end

      // An explicit Q load beats any shift; load M freezes Q otherwise.
      if (c[C_LOAD_Q]) begin
        q <= inbus;
      end else if (!c[C_LOAD_M]) begin
        q <= q_nxt;
      end

      if (c[C_OUT_A]) begin
        outbus <= a[WIDTH-1:0];
      end else if (c[C_OUT_Q]) begin
        outbus <= q;
      end
      out_valid <= c[C_OUT_A] | c[C_OUT_Q];
    end
  end

  assign q0  = q[0];
  assign q_1 = q1;
  assign a_8 = a[WIDTH];
  assign cnt = cnt_r;
`ifdef ALU_DATAPATH_OVF_EN
  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: reset, Booth multiply, priority rules,
// counter wrap, restoring divide and (optionally) the overflow flag.
// Latency: one control step per clock; outputs sampled 1 time unit after edge.
module tb_alu_datapath;

  localparam logic [10:0] C0  = 11'h001;
  localparam logic [10:0] C1  = 11'h002;
  localparam logic [10:0] C2  = 11'h004;
  localparam logic [10:0] C3  = 11'h008;
  localparam logic [10:0] C4  = 11'h010;
  localparam logic [10:0] C5  = 11'h020;
  localparam logic [10:0] C6  = 11'h040;
  localparam logic [10:0] C7  = 11'h080;
  localparam logic [10:0] C8  = 11'h100;
  localparam logic [10:0] C9  = 11'h200;
  localparam logic [10:0] C10 = 11'h400;

  logic        clk;
  logic        rst_b;
  logic [10:0] c;
  logic [7:0]  inbus;
  logic        q0;
  logic        q_1;
  logic        a_8;
  logic [2:0]  cnt;
  logic [7:0]  outbus;
  logic        out_valid;
`ifdef ALU_DATAPATH_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  alu_datapath #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .c         (c),
    .inbus     (inbus),
    .q0        (q0),
    .q_1       (q_1),
    .a_8       (a_8),
    .cnt       (cnt),
    .outbus    (outbus),
`ifdef ALU_DATAPATH_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Apply one control word for exactly one rising edge, then sample.
  task automatic step(input logic [10:0] cv, input logic [7:0] iv);
    c     = cv;
    inbus = iv;
    @(posedge clk);
    #1;
    c     = '0;
    inbus = '0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    step(11'h7FF, 8'hA5);
    total++; if ({q0, q_1, a_8} !== 3'b000) begin bad++; $display("FAIL reset_bits got=%b exp=000", {q0, q_1, a_8}); end
    total++; if (cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    total++; if (outbus !== 8'h00) begin bad++; $display("FAIL reset_outbus got=%h exp=00", outbus); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    rst_b = 1'b1;
    // Build up state, then reset mid-operation.
    step(C0, 8'h85);
    step(C1, 8'h33);
    step(C2 | C5, 8'h00);
    total++; if ({a_8, q0, cnt} !== 5'b11001) begin bad++; $display("FAIL preset_state got=%b exp=11001", {a_8, q0, cnt}); end
    rst_b = 1'b0;
    step(11'h7FF, 8'hFF);
    rst_b = 1'b1;
    total++; if ({a_8, q0, q_1, cnt} !== 6'b0) begin bad++; $display("FAIL midreset_state got=%b exp=000000", {a_8, q0, q_1, cnt}); end
    step(C7, 8'h00);
    total++; if (outbus !== 8'h00 || out_valid !== 1'b1) begin bad++; $display("FAIL midreset_q got=%h/%b exp=00/1", outbus, out_valid); end
    step(C2, 8'h00);
    step(C6, 8'h00);
    total++; if (outbus !== 8'h00) begin bad++; $display("FAIL midreset_m got=%h exp=00", outbus); end
  endtask

  task automatic test_booth();
    logic [10:0] cv;
    step(C0, 8'd5);
    step(C1, 8'hFD);
    for (int i = 0; i < 8; i++) begin
      cv = C4 | C5;
      if (q0 && !q_1) cv = cv | C3;
      else if (!q0 && q_1) cv = cv | C2;
      step(cv, 8'h00);
    end
    total++; if (cnt !== 3'd0) begin bad++; $display("FAIL booth_cnt got=%0d exp=0", cnt); end
    total++; if (a_8 !== 1'b1) begin bad++; $display("FAIL booth_sign got=%b exp=1", a_8); end
    step(C6, 8'h00);
    total++; if (outbus !== 8'hFF || out_valid !== 1'b1) begin bad++; $display("FAIL booth_hi got=%h/%b exp=ff/1", outbus, out_valid); end
    step(C7, 8'h00);
    total++; if (outbus !== 8'hF1 || out_valid !== 1'b1) begin bad++; $display("FAIL booth_lo got=%h/%b exp=f1/1", outbus, out_valid); end
    step(11'h000, 8'h00);
    total++; if (outbus !== 8'hF1 || out_valid !== 1'b0) begin bad++; $display("FAIL booth_hold got=%h/%b exp=f1/0", outbus, out_valid); end
  endtask

  task automatic test_priority();
    step(C0, 8'd4);
    step(C2 | C3, 8'h00);
    total++; if (a_8 !== 1'b1) begin bad++; $display("FAIL prio_sub_sign got=%b exp=1", a_8); end
    step(C6, 8'h00);
    total++; if (outbus !== 8'hFC) begin bad++; $display("FAIL prio_sub got=%h exp=fc", outbus); end
    step(C1, 8'h81);
    step(C0 | C4, 8'd4);
    total++; if ({a_8, q0, q_1} !== 3'b010) begin bad++; $display("FAIL prio_load_noshift got=%b exp=010", {a_8, q0, q_1}); end
    step(C7, 8'h00);
    total++; if (outbus !== 8'h81) begin bad++; $display("FAIL prio_load_q got=%h exp=81", outbus); end
    step(C6, 8'h00);
    total++; if (outbus !== 8'h00) begin bad++; $display("FAIL prio_load_a got=%h exp=00", outbus); end
    // Opposing shifts cancel, add still applies.
    step(C2 | C4 | C8, 8'h00);
    step(C6, 8'h00);
    total++; if (outbus !== 8'h04) begin bad++; $display("FAIL both_shift_a got=%h exp=04", outbus); end
    step(C7, 8'h00);
    total++; if (outbus !== 8'h81 || q_1 !== 1'b0) begin bad++; $display("FAIL both_shift_q got=%h/%b exp=81/0", outbus, q_1); end
    // Correction ignored alongside subtract; acts alone only on negative A.
    step(C3, 8'h00);
    step(C3, 8'h00);
    step(C3 | C10, 8'h00);
    step(C6, 8'h00);
    total++; if (outbus !== 8'hF8) begin bad++; $display("FAIL corr_with_sub got=%h exp=f8", outbus); end
    step(C10, 8'h00);
    step(C6, 8'h00);
    total++; if (outbus !== 8'hFC) begin bad++; $display("FAIL corr_neg got=%h exp=fc", outbus); end
    step(C10, 8'h00);
    step(C10, 8'h00);
    step(C6, 8'h00);
    total++; if (outbus !== 8'h00 || a_8 !== 1'b0) begin bad++; $display("FAIL corr_pos_noop got=%h/%b exp=00/0", outbus, a_8); end
  endtask

  task automatic test_cnt_wrap();
    step(C0, 8'h00);
    for (int i = 0; i < 7; i++) step(C5, 8'h00);
    total++; if (cnt !== 3'd7) begin bad++; $display("FAIL cnt_seven got=%0d exp=7", cnt); end
    step(C5, 8'h00);
    total++; if (cnt !== 3'd0) begin bad++; $display("FAIL cnt_wrap got=%0d exp=0", cnt); end
  endtask

  task automatic test_division();
    step(C0, 8'd4);
    step(C1, 8'd13);
    for (int i = 0; i < 8; i++) begin
      step(C8, 8'h00);
      step(C3 | C9, 8'h00);
      step(C10, 8'h00);
    end
    total++; if (a_8 !== 1'b0) begin bad++; $display("FAIL div_sign got=%b exp=0", a_8); end
    step(C7, 8'h00);
    total++; if (outbus !== 8'd3) begin bad++; $display("FAIL div_quot got=%h exp=03", outbus); end
    step(C6, 8'h00);
    total++; if (outbus !== 8'd1) begin bad++; $display("FAIL div_rem got=%h exp=01", outbus); end
  endtask

`ifdef ALU_DATAPATH_OVF_EN
  task automatic test_ovf();
    step(C0, 8'd127);
    step(C2, 8'h00);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_none got=%b exp=0", ovf); end
    step(C2, 8'h00);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    step(C1, 8'h00);
    step(11'h000, 8'h00);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    step(C0, 8'd1);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
  endtask
`endif

  initial begin
    clk   = 1'b0;
    rst_b = 1'b0;
    c     = '0;
    inbus = '0;
    test_reset();
    test_booth();
    test_priority();
    test_cnt_wrap();
    test_division();
`ifdef ALU_DATAPATH_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
